// File: rtl/muldiv_controller_pkg.sv
// rtl/muldiv_controller_pkg.sv - shared widths, op and state encodings for the HI/LO multiply/divide unit
package muldiv_controller_pkg;

    localparam int MD_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_controller_if.sv
// rtl/muldiv_controller_if.sv - pipeline-facing request, MTHI/MTLO and HI/LO result bundle
interface muldiv_controller_if
    import muldiv_controller_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] rs;
    logic [DATA_WIDTH-1:0] rt;
    logic                  flush;
    logic                  hi_we;
    logic                  lo_we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  hilo_rd;
    logic                  busy;
    logic                  done;
    logic                  stall;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, rs, rt, flush, hi_we, lo_we, wdata, hilo_rd,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, flush, hi_we, lo_we, wdata, hilo_rd,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_controller_step.sv
// rtl/muldiv_controller_step.sv - one radix-2 shift-add or restoring subtract-shift step
module muldiv_controller_step
    import muldiv_controller_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] upper,
    input  logic [DATA_WIDTH-1:0] lower,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] upper_next,
    output logic [DATA_WIDTH-1:0] lower_next
);
    localparam int W = DATA_WIDTH;

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         ge;

    always_comb begin
        sum     = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        shifted = {upper, lower[W-1]};
        ge      = shifted >= {1'b0, operand};
        // shifted < 2*operand whenever ge holds, so the low W bits carry the full difference
        diff    = shifted[W-1:0] - operand;
        if (is_div) begin
            upper_next = ge ? diff : shifted[W-1:0];
            lower_next = {lower[W-2:0], ge};
        end else begin
            upper_next = sum[W:1];
            lower_next = {sum[0], lower[W-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_controller.sv
// rtl/muldiv_controller.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module muldiv_controller
    import muldiv_controller_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    muldiv_controller_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    md_state_e     state, state_next;
    logic [CW-1:0] count;
    logic [W-1:0]  upper, lower, divisor, rs_keep, hi_q, lo_q;
    logic [W-1:0]  upper_step, lower_step, rs_abs, rt_abs;
    logic          div_q, neg_res, neg_rem, div_zero;
    logic          rs_neg, rt_neg, busy;

    always_comb begin
        rs_neg = op_is_signed(bus.op) & bus.rs[W-1];
        rt_neg = op_is_signed(bus.op) & bus.rt[W-1];
        rs_abs = rs_neg ? -bus.rs : bus.rs;
        rt_abs = rt_neg ? -bus.rt : bus.rt;
    end

    muldiv_controller_step #(.DATA_WIDTH(W)) u_step (
        .is_div     (div_q),
        .upper      (upper),
        .lower      (lower),
        .operand    (divisor),
        .upper_next (upper_step),
        .lower_next (lower_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_CALC;
            ST_CALC: if (count == '0) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
        if (bus.flush) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            upper    <= '0;
            lower    <= '0;
            divisor  <= '0;
            rs_keep  <= '0;
            div_q    <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (state == ST_IDLE && bus.start && !bus.flush) begin
                upper    <= '0;
                lower    <= rs_abs;
                divisor  <= rt_abs;
                rs_keep  <= bus.rs;
                div_q    <= op_is_div(bus.op);
                neg_res  <= rs_neg ^ rt_neg;
                neg_rem  <= rs_neg;
                div_zero <= (bus.rt == '0);
                count    <= CW'(W - 1);
            end
            if (state == ST_CALC) begin
                upper <= upper_step;
                lower <= lower_step;
                if (count != '0) count <= count - 1'b1;
                // Commit on the edge entering DONE, using this cycle's final step
                if (count == '0 && !bus.flush) begin
                    if (!div_q) begin
                        {hi_q, lo_q} <= neg_res ? -{upper_step, lower_step} : {upper_step, lower_step};
                    end else if (div_zero) begin
                        lo_q <= '1;
                        hi_q <= rs_keep;
                    end else begin
                        lo_q <= neg_res ? -lower_step : lower_step;
                        hi_q <= neg_rem ? -upper_step : upper_step;
                    end
                end
            end else begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign busy      = (state == ST_CALC);
    assign bus.busy  = busy;
    assign bus.done  = (state == ST_DONE);
    assign bus.stall = busy & (bus.start | bus.hilo_rd | bus.hi_we | bus.lo_we);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_controller.sv
// tb/tb_muldiv_controller.sv - randomized and directed checks of muldiv_controller against an arithmetic model
module tb_muldiv_controller;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    muldiv_controller_if #(.DATA_WIDTH(W)) bus ();

    muldiv_controller #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        mhi = '0;
        mlo = '0;
        case (op)
            2'b00: begin p = sa * sb; {mhi, mlo} = p; end
            2'b01: begin up = ua * ub; {mhi, mlo} = up; end
            2'b10: begin
                if (b == 0) begin mlo = '1; mhi = a; end
                else begin
                    p = sa / sb; mlo = p[31:0];
                    p = sa % sb; mhi = p[31:0];
                end
            end
            default: begin
                if (b == 0) begin mlo = '1; mhi = a; end
                else begin
                    up = ua / ub; mlo = up[31:0];
                    up = ua % ub; mhi = up[31:0];
                end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        int          edges, busy_cnt;
        model(op, a, b, ehi, elo);
        bus.op = op; bus.rs = a; bus.rt = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        edges = 1;
        busy_cnt = 0;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_cnt++;
            tick();
            edges++;
        end
        chk({tag, ".latency"}, 64'(edges), 64'(W + 1));
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(W));
        chk({tag, ".hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        chk({tag, ".lo"}, {32'd0, bus.lo}, {32'd0, elo});
        tick();
        chk({tag, ".done_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        logic [31:0] hold_hi, hold_lo, r_rs, r_rt;
        logic [1:0]  r_op;
        int          guard;
        logic        saw_done;

        bus.start = 0; bus.op = 0; bus.rs = 0; bus.rt = 0; bus.flush = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0; bus.hilo_rd = 0;
        #2;
        chk("reset.hi", {32'd0, bus.hi}, 64'd0);
        chk("reset.lo", {32'd0, bus.lo}, 64'd0);
        chk("reset.busy", {63'd0, bus.busy}, 64'd0);
        chk("reset.done", {63'd0, bus.done}, 64'd0);
        chk("reset.stall", {63'd0, bus.stall}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7);
        chk("mult_neg3x7.abs_hi", {32'd0, bus.hi}, 64'hFFFFFFFF);
        chk("mult_neg3x7.abs_lo", {32'd0, bus.lo}, 64'hFFFFFFEB);
        run_op("div_neg7by2", 2'b10, 32'hFFFFFFF9, 32'd2);
        chk("div_neg7by2.abs_lo", {32'd0, bus.lo}, 64'hFFFFFFFD);
        chk("div_neg7by2.abs_hi", {32'd0, bus.hi}, 64'hFFFFFFFF);
        run_op("divu_7by0", 2'b11, 32'd7, 32'd0);
        chk("divu_7by0.abs_lo", {32'd0, bus.lo}, 64'hFFFFFFFF);
        chk("divu_7by0.abs_hi", {32'd0, bus.hi}, 64'd7);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max.abs_hi", {32'd0, bus.hi}, 64'hFFFFFFFE);
        chk("multu_max.abs_lo", {32'd0, bus.lo}, 64'h00000001);
        run_op("div_minby_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF);
        chk("div_minby_m1.abs_lo", {32'd0, bus.lo}, 64'h80000000);
        chk("div_minby_m1.abs_hi", {32'd0, bus.hi}, 64'd0);
        run_op("div_neg5by0", 2'b10, 32'hFFFFFFFB, 32'd0);
        run_op("div_7byneg2", 2'b10, 32'd7, 32'hFFFFFFFE);

        // Pipeline hazards during a DIV: stall raised, MTHI ignored
        bus.op = 2'b10; bus.rs = 32'd100; bus.rt = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        hold_hi = bus.hi;
        bus.hilo_rd = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'd5;
        #1;
        chk("stall.raised", {63'd0, bus.stall}, 64'd1);
        tick();
        chk("stall.mthi_ignored", {32'd0, bus.hi}, {32'd0, hold_hi});
        bus.hi_we = 1'b0;
        guard = 0;
        while (!bus.done && guard < 100) begin tick(); guard++; end
        chk("stall.done_seen", {63'd0, bus.done}, 64'd1);
        chk("stall.dropped_in_done", {63'd0, bus.stall}, 64'd0);
        chk("stall.lo", {32'd0, bus.lo}, 64'd14);
        chk("stall.hi", {32'd0, bus.hi}, 64'd2);
        bus.hilo_rd = 1'b0;
        tick();

        // MTHI/MTLO in IDLE
        bus.hi_we = 1'b1; bus.wdata = 32'h12;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h34;
        tick();
        bus.lo_we = 1'b0;
        chk("mthi.idle", {32'd0, bus.hi}, 64'h12);
        chk("mtlo.idle", {32'd0, bus.lo}, 64'h34);

        // Flush mid-MULT: back to IDLE, no done, HI/LO kept
        bus.op = 2'b00; bus.rs = 32'd3; bus.rt = 32'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush.busy", {63'd0, bus.busy}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            saw_done |= bus.done;
            tick();
        end
        chk("flush.no_done", {63'd0, saw_done}, 64'd0);
        chk("flush.hi_kept", {32'd0, bus.hi}, 64'h12);
        chk("flush.lo_kept", {32'd0, bus.lo}, 64'h34);

        // Flush wins over same-cycle start
        bus.start = 1'b1; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_vs_start.busy", {63'd0, bus.busy}, 64'd0);

        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_rs = $urandom;
            case ($urandom_range(0, 3))
                0:       r_rt = 32'd0;
                1:       r_rt = $urandom_range(1, 9);
                2:       r_rt = -$urandom_range(1, 9);
                default: r_rt = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_rs, r_rt);
        end

        // Asynchronous reset in the middle of a DIV
        run_op("pre_reset", 2'b11, 32'd1000, 32'd7);
        bus.op = 2'b10; bus.rs = 32'd99; bus.rt = 32'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset.hi", {32'd0, bus.hi}, 64'd0);
        chk("async_reset.lo", {32'd0, bus.lo}, 64'd0);
        chk("async_reset.busy", {63'd0, bus.busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("post_reset", 2'b00, 32'd6, 32'hFFFFFFF9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
